// File: rtl/arm_pipe_pkg.sv
// Shared pipeline constants and the width helpers that size register
// addresses and per-register in-flight counters.
package arm_pipe_pkg;

  localparam int DEFAULT_REG_COUNT    = 16;
  localparam int DEFAULT_MAX_INFLIGHT = 4;

  // Never returns less than 1, so degenerate sizes still give legal vectors.
  function automatic int width_for(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int ra_width(input int reg_count);
    return width_for(reg_count);
  endfunction

  function automatic int cnt_width(input int max_inflight);
    return width_for(max_inflight + 1);
  endfunction

endpackage

// File: rtl/hazard_scoreboard_sb_entry.sv
// One scoreboard cell: pending-writer count and load-pending flag for a
// single architectural register.
module sb_entry
  import arm_pipe_pkg::*;
#(
  parameter int MAX_INFLIGHT = DEFAULT_MAX_INFLIGHT,
  parameter int CNT_W        = cnt_width(DEFAULT_MAX_INFLIGHT)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             dec,
  input  logic             ld_set,
  input  logic             ld_clr,
  output logic [CNT_W-1:0] cnt,
  output logic             ld,
  output logic             err_inc,
  output logic             err_dec
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ld_q, ld_d;
  logic             at_max, at_zero;

  assign at_max  = (cnt_q == CNT_W'(MAX_INFLIGHT));
  assign at_zero = (cnt_q == '0);

  // A simultaneous issue and retire on this register cancel out; only an
  // unmatched overflow or underflow is refused and reported.
  assign err_inc = inc & ~dec & at_max;
  assign err_dec = dec & at_zero;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && !dec && !at_max) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (dec && !inc && !at_zero) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_comb begin
    ld_d = ld_q;
    if (ld_set) begin
      ld_d = 1'b1;
    end else if (ld_clr) begin
      ld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      ld_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ld_q  <= ld_d;
    end
  end

  assign cnt = cnt_q;
  assign ld  = ld_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// Register hazard scoreboard: tracks in-flight writers per register and
// freezes the front end while an ID-stage source is not yet available.
module hazard_scoreboard
  import arm_pipe_pkg::*;
#(
  parameter int REG_COUNT    = DEFAULT_REG_COUNT,
  parameter int MAX_INFLIGHT = DEFAULT_MAX_INFLIGHT,
  parameter int PCNT_W       = 16
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [ra_width(REG_COUNT)-1:0]  rn_id,
  input  logic [ra_width(REG_COUNT)-1:0]  src2_id,
  input  logic                            two_src_id,
  input  logic                            issue_valid_id,
  input  logic                            wb_en_id,
  input  logic                            mem_read_id,
  input  logic [ra_width(REG_COUNT)-1:0]  dst_id,
  input  logic                            flush,
  input  logic                            forwarding_en,
  input  logic                            mem_stall,
  input  logic                            load_done,
  input  logic [ra_width(REG_COUNT)-1:0]  load_dst,
  input  logic                            retire,
  input  logic [ra_width(REG_COUNT)-1:0]  retire_dst,
  input  logic                            pcnt_clr,
  output logic                            freeze,
  output logic [REG_COUNT-1:0]            busy_vec,
  output logic [PCNT_W-1:0]               freeze_cycles,
  output logic                            sb_err
);

  localparam int RA_W  = ra_width(REG_COUNT);
  localparam int CNT_W = cnt_width(MAX_INFLIGHT);

  logic                 issue;
  logic [REG_COUNT-1:0] ld_vec, haz_vec, err_inc_vec, err_dec_vec;
  logic                 haz_rn, haz_src2;
  logic [PCNT_W-1:0]    pcnt_q, pcnt_d;
  logic                 sb_err_q, sb_err_d;

  assign issue = issue_valid_id & ~freeze & ~flush;

  for (genvar r = 0; r < REG_COUNT; r++) begin : g_entry
    logic [CNT_W-1:0] cnt;
    logic             hit_dst, hit_ret, hit_load;

    assign hit_dst  = (dst_id == RA_W'(r));
    assign hit_ret  = retire & (retire_dst == RA_W'(r));
    assign hit_load = load_done & (load_dst == RA_W'(r));

    sb_entry #(
      .MAX_INFLIGHT(MAX_INFLIGHT),
      .CNT_W       (CNT_W)
    ) u_entry (
      .clk    (clk),
      .rst_n  (rst_n),
      .inc    (issue & wb_en_id & hit_dst),
      .dec    (hit_ret),
      .ld_set (issue & wb_en_id & mem_read_id & hit_dst),
      .ld_clr (hit_load),
      .cnt    (cnt),
      .ld     (ld_vec[r]),
      .err_inc(err_inc_vec[r]),
      .err_dec(err_dec_vec[r])
    );

    assign busy_vec[r] = (cnt != '0);

    // Without forwarding, the last outstanding writer retiring this very
    // cycle is written through the register file and counts as available.
    assign haz_vec[r] = forwarding_en
                      ? (ld_vec[r] & ~hit_load)
                      : (busy_vec[r] & ~((cnt == CNT_W'(1)) & hit_ret));
  end

  assign haz_rn   = haz_vec[rn_id];
  assign haz_src2 = two_src_id & haz_vec[src2_id];
  assign freeze   = mem_stall | (issue_valid_id & (haz_rn | haz_src2));

  always_comb begin
    pcnt_d = pcnt_q;
    if (pcnt_clr) begin
      pcnt_d = '0;
    end else if (freeze && (pcnt_q != '1)) begin
      pcnt_d = pcnt_q + PCNT_W'(1);
    end
  end

  assign sb_err_d = sb_err_q | (|err_inc_vec) | (|err_dec_vec);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt_q   <= '0;
      sb_err_q <= 1'b0;
    end else begin
      pcnt_q   <= pcnt_d;
      sb_err_q <= sb_err_d;
    end
  end

  assign freeze_cycles = pcnt_q;
  assign sb_err        = sb_err_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed self-checking bench for hazard_scoreboard with hand-computed
// expectations for each scenario.
module tb_hazard_scoreboard;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  rn_id, src2_id, dst_id, load_dst, retire_dst;
  logic        two_src_id, issue_valid_id, wb_en_id, mem_read_id, flush;
  logic        forwarding_en, mem_stall, load_done, retire, pcnt_clr;
  logic        freeze, sb_err;
  logic [15:0] busy_vec, freeze_cycles;

  int checkCount = 0;
  int errorCount = 0;

  hazard_scoreboard dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .rn_id         (rn_id),
    .src2_id       (src2_id),
    .two_src_id    (two_src_id),
    .issue_valid_id(issue_valid_id),
    .wb_en_id      (wb_en_id),
    .mem_read_id   (mem_read_id),
    .dst_id        (dst_id),
    .flush         (flush),
    .forwarding_en (forwarding_en),
    .mem_stall     (mem_stall),
    .load_done     (load_done),
    .load_dst      (load_dst),
    .retire        (retire),
    .retire_dst    (retire_dst),
    .pcnt_clr      (pcnt_clr),
    .freeze        (freeze),
    .busy_vec      (busy_vec),
    .freeze_cycles (freeze_cycles),
    .sb_err        (sb_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    if (obs !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic iv, input logic wb, input logic mr,
                               input logic [3:0] dst, input logic [3:0] rn);
    issue_valid_id = iv;
    wb_en_id       = wb;
    mem_read_id    = mr;
    dst_id         = dst;
    rn_id          = rn;
    #1;
  endtask

  task automatic idleInputs();
    rn_id = 0; src2_id = 0; dst_id = 0; load_dst = 0; retire_dst = 0;
    two_src_id = 0; issue_valid_id = 0; wb_en_id = 0; mem_read_id = 0;
    flush = 0; forwarding_en = 0; mem_stall = 0; load_done = 0;
    retire = 0; pcnt_clr = 0;
  endtask

  initial begin
    idleInputs();
    rst_n = 1'b0;
    mem_stall = 1'b1;
    #2;
    checkOutput("rst_busy", busy_vec, 16'h0000);
    checkOutput("rst_pcnt", freeze_cycles, 0);
    checkOutput("rst_err", sb_err, 0);
    checkOutput("rst_freeze_stall", freeze, 1);
    mem_stall = 1'b0;
    #1;
    checkOutput("rst_freeze_idle", freeze, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Forwarding off: RAW on R3 released by same-cycle retire
    applyStimulus(1, 1, 0, 4'd3, 4'd0);
    checkOutput("s1_issue_free", freeze, 0);
    tick();
    checkOutput("s1_busy3", busy_vec, 16'h0008);
    applyStimulus(1, 0, 0, 4'd0, 4'd3);
    checkOutput("s1_raw_freeze", freeze, 1);
    tick();
    checkOutput("s1_raw_freeze2", freeze, 1);
    tick();
    retire = 1; retire_dst = 4'd3;
    #1;
    checkOutput("s1_write_through", freeze, 0);
    tick();
    retire = 0;
    applyStimulus(0, 0, 0, 4'd0, 4'd0);
    checkOutput("s1_busy_clear", busy_vec, 16'h0000);
    checkOutput("s1_pcnt", freeze_cycles, 2);

    // Forwarding on: load-use on R5 via second source
    forwarding_en = 1;
    applyStimulus(1, 1, 1, 4'd5, 4'd0);
    checkOutput("s2_ldr_free", freeze, 0);
    tick();
    applyStimulus(1, 0, 0, 4'd0, 4'd0);
    src2_id = 4'd5; two_src_id = 0;
    #1;
    checkOutput("s2_src2_ignored", freeze, 0);
    two_src_id = 1;
    #1;
    checkOutput("s2_load_use", freeze, 1);
    tick();
    load_done = 1; load_dst = 4'd5;
    #1;
    checkOutput("s2_load_done", freeze, 0);
    tick();
    load_done = 0; two_src_id = 0;
    checkOutput("s2_busy5", busy_vec, 16'h0020);
    forwarding_en = 0;
    applyStimulus(1, 0, 0, 4'd0, 4'd5);
    checkOutput("s2_nofwd_raw", freeze, 1);
    retire = 1; retire_dst = 4'd5;
    #1;
    checkOutput("s2_nofwd_wt", freeze, 0);
    tick();
    retire = 0;
    applyStimulus(0, 0, 0, 4'd0, 4'd0);
    checkOutput("s2_busy_clear", busy_vec, 16'h0000);
    checkOutput("s2_pcnt", freeze_cycles, 3);

    // Two writers to R2, retired one at a time
    applyStimulus(1, 1, 0, 4'd2, 4'd0);
    tick();
    tick();
    applyStimulus(1, 0, 0, 4'd0, 4'd2);
    retire = 1; retire_dst = 4'd2;
    #1;
    checkOutput("s3_cnt2_no_wt", freeze, 1);
    tick();
    checkOutput("s3_busy_after1", busy_vec, 16'h0004);
    checkOutput("s3_cnt1_wt", freeze, 0);
    tick();
    retire = 0;
    applyStimulus(0, 0, 0, 4'd0, 4'd0);
    checkOutput("s3_busy_after2", busy_vec, 16'h0000);

    // Flushed instruction must not touch the scoreboard
    flush = 1;
    applyStimulus(1, 1, 1, 4'd10, 4'd0);
    tick();
    flush = 0;
    applyStimulus(0, 0, 0, 4'd0, 4'd0);
    checkOutput("flush_no_track", busy_vec, 16'h0000);

    // Underflow on R7
    checkOutput("s4_err_before", sb_err, 0);
    retire = 1; retire_dst = 4'd7;
    tick();
    retire = 0;
    checkOutput("s4_err_set", sb_err, 1);
    checkOutput("s4_no_wrap", busy_vec, 16'h0000);
    tick(); tick();
    checkOutput("s4_err_sticky", sb_err, 1);

    // Freeze counter under mem_stall, then clear priority
    pcnt_clr = 1;
    tick();
    pcnt_clr = 0;
    checkOutput("s5_pcnt_clr", freeze_cycles, 0);
    mem_stall = 1;
    #1;
    checkOutput("s5_stall_freeze", freeze, 1);
    for (int i = 0; i < 5; i++) tick();
    mem_stall = 0;
    checkOutput("s5_pcnt5", freeze_cycles, 5);
    mem_stall = 1; pcnt_clr = 1;
    tick();
    mem_stall = 0; pcnt_clr = 0;
    checkOutput("s5_clr_priority", freeze_cycles, 0);

    // Reset mid-operation with R4 pending
    applyStimulus(1, 1, 1, 4'd4, 4'd0);
    tick();
    tick();
    applyStimulus(0, 0, 0, 4'd0, 4'd0);
    checkOutput("s6_busy4", busy_vec, 16'h0010);
    rst_n = 0;
    #1;
    checkOutput("s6_rst_busy", busy_vec, 16'h0000);
    checkOutput("s6_rst_err", sb_err, 0);
    @(negedge clk);
    rst_n = 1;
    tick();
    applyStimulus(1, 0, 0, 4'd0, 4'd4);
    checkOutput("s6_nofwd_free", freeze, 0);
    forwarding_en = 1;
    #1;
    checkOutput("s6_fwd_free", freeze, 0);
    forwarding_en = 0;
    applyStimulus(0, 0, 0, 4'd0, 4'd0);
    retire = 1; retire_dst = 4'd4;
    tick();
    retire = 0;
    checkOutput("s6_no_credit", sb_err, 1);

    // Overflow on R9: fifth writer refused
    rst_n = 0;
    #1;
    rst_n = 1;
    tick();
    applyStimulus(1, 1, 0, 4'd9, 4'd0);
    for (int i = 0; i < 4; i++) tick();
    checkOutput("ovf_none_yet", sb_err, 0);
    tick();
    applyStimulus(0, 0, 0, 4'd0, 4'd0);
    checkOutput("ovf_err", sb_err, 1);
    retire = 1; retire_dst = 4'd9;
    for (int i = 0; i < 3; i++) tick();
    checkOutput("ovf_still_busy", busy_vec, 16'h0200);
    tick();
    retire = 0;
    checkOutput("ovf_saturated", busy_vec, 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 SHALL have parameter REG_COUNT, default 16, number of architectural registers.
REQ-002 SHALL have parameter MAX_INFLIGHT, default 4, maximum issued-but-unretired writers per register.
REQ-003 SHALL have parameter PCNT_W, default 16, freeze-cycle counter width.
REQ-004 SHALL derive RA_W = clog2(REG_COUNT) and CNT_W = clog2(MAX_INFLIGHT+1).
REQ-005 SHALL have ports, one per line:
clk  in  1  sole clock, rising edge
rst_n  in  1  asynchronous active-low reset
rn_id  in  RA_W  first source register in ID
src2_id  in  RA_W  second source register in ID
two_src_id  in  1  src2_id is valid
issue_valid_id  in  1  ID holds a real instruction
wb_en_id  in  1  ID instruction writes a register
mem_read_id  in  1  ID instruction is a load
dst_id  in  RA_W  ID destination register
flush  in  1  ID instruction is squashed this cycle
forwarding_en  in  1  forwarding unit active
mem_stall  in  1  data memory not ready
load_done  in  1  pulse: load data reached forwardable point
load_dst  in  RA_W  register of completing load
retire  in  1  pulse: register-file write this cycle
retire_dst  in  RA_W  register written
pcnt_clr  in  1  synchronous clear of freeze counter
freeze  out  1  hold PC and IF/ID, bubble into EXE
busy_vec  out  REG_COUNT  bit r set when count[r] != 0
freeze_cycles  out  PCNT_W  saturating freeze-cycle count
sb_err  out  1  sticky scoreboard error

Function
REQ-006 SHALL keep per-register pending count cnt[r] (CNT_W bits) and load-pending flag ld[r].
REQ-007 SHALL define issue = issue_valid_id & ~freeze & ~flush; issue SHALL occur at most once per cycle.
REQ-008 SHALL on issue & wb_en_id increment cnt[dst_id]; on retire decrement cnt[retire_dst]; same register both SHALL leave cnt unchanged.
REQ-009 SHALL on issue & mem_read_id & wb_en_id set ld[dst_id]; load_done SHALL clear ld[load_dst]; simultaneous set and clear on same register SHALL leave ld set.
REQ-010 SHALL treat a source as hazardous: forwarding_en=0 -> cnt[src] != 0, except cnt[src]==1 with retire & retire_dst==src (same-cycle write-through), which SHALL be free; forwarding_en=1 -> ld[src]=1 and not (load_done & load_dst==src).
REQ-011 SHALL check rn_id always and src2_id only when two_src_id=1.
REQ-012 SHALL drive freeze combinationally = mem_stall | (issue_valid_id & any source hazardous); no register between scoreboard state and freeze.
REQ-013 SHALL increment freeze_cycles each cycle freeze=1, saturating at all-ones; pcnt_clr SHALL zero it and take priority over increment.
REQ-014 SHALL set sb_err on retire with cnt[retire_dst]==0 (no decrement, no wrap) or on increment with cnt[dst_id]==MAX_INFLIGHT (no increment); sb_err SHALL clear only on reset.
REQ-015 SHALL ignore wb_en_id, mem_read_id when issue=0; flush SHALL never alter cnt or ld.
REQ-016 SHALL update cnt, ld, freeze_cycles, sb_err on the rising clk edge; retire and load_done SHALL be honoured even while freeze=1.

Reset
REQ-017 SHALL on rst_n=0 immediately clear all cnt and ld, freeze_cycles=0, sb_err=0, busy_vec=0; freeze SHALL then equal mem_stall.
REQ-018 SHALL discard any in-flight tracking on reset mid-operation; no retire credit survives reset.

Structure
REQ-019 SHALL place RA_W/CNT_W derivation helpers and default REG_COUNT, MAX_INFLIGHT in shared package arm_pipe_pkg.
REQ-020 SHALL implement one per-register counter/flag cell as sub-module sb_entry, instantiated REG_COUNT times.

Verification
REQ-021 Fwd off: issue ADD dst=R3, next ID reads rn=R3 -> freeze=1 until retire R3 cycle (write-through), then freeze=0.
REQ-022 Fwd on: issue LDR dst=R5, next ID src2=R5 two_src=1 -> freeze=1 one cycle; load_done R5 same cycle -> freeze=0.
REQ-023 Two writers R2 back-to-back, one retire -> busy_vec[2]=1, cnt=1; second retire -> busy_vec[2]=0.
REQ-024 Retire R7 with cnt[7]=0 -> sb_err=1, cnt[7] stays 0; persists until rst_n low.
REQ-025 mem_stall=1 for 5 cycles, no hazards -> freeze_cycles=5; pcnt_clr with freeze=1 -> 0 next cycle.
REQ-026 rst_n low while cnt[4]=2, ld[4]=1 -> busy_vec=0 immediately; ID reads R4 after release -> freeze=0.
